fsic_is_rx_fifo: RTL and testbench
==================================

Name: fsic_is_rx_fifo

Overview:
- Receive-side AXI-Stream buffer between the IO serdes Rx outputs (is_as_*) and the local axis switch.
- The serdes link has no per-beat backpressure, so every beat with is_as_tvalid=1 must be captured.
- The block stores those beats, replays them on an AXI-Stream master port, and drives as_is_tready back toward the serdes TX path. That signal is the link-level flow control telling the remote side to stop sending.

Parameters:
- pDATA_WIDTH, 32, tdata width; tstrb/tkeep width = pDATA_WIDTH/8.
- pDEPTH, 8, FIFO entries; any value >= 2, not necessarily a power of 2.
- pTHRESHOLD, 3, free-entry watermark. as_is_tready=0 when free entries <= pTHRESHOLD. Must satisfy 0 < pTHRESHOLD < pDEPTH; covers the serdes round-trip skid.

Ports:
- axis_clk  in  1  sole clock.
- axis_rst  in  1  synchronous, active-high reset.
- is_as_tdata  in  pDATA_WIDTH  beat from serdes Rx.
- is_as_tstrb  in  pDATA_WIDTH/8  beat from serdes Rx.
- is_as_tkeep  in  pDATA_WIDTH/8  beat from serdes Rx.
- is_as_tid  in  2  beat from serdes Rx.
- is_as_tuser  in  2  beat from serdes Rx.
- is_as_tlast  in  1  beat from serdes Rx.
- is_as_tvalid  in  1  beat present; no ready is returned.
- as_is_tready  out  1  local flow control toward remote, sent via serdes TX.
- m_tdata  out  pDATA_WIDTH  head-entry field.
- m_tstrb  out  pDATA_WIDTH/8  head-entry field.
- m_tkeep  out  pDATA_WIDTH/8  head-entry field.
- m_tid  out  2  head-entry field.
- m_tuser  out  2  head-entry field.
- m_tlast  out  1  head-entry field.
- m_tvalid  out  1  FIFO non-empty.
- m_tready  in  1  downstream accept.
- fifo_count  out  $clog2(pDEPTH+1)  occupied entries.
- overflow  out  1  sticky: a beat was dropped.
- drop_cnt  out  8  saturating count of dropped beats.
- ovf_clr  in  1  clears overflow and drop_cnt.

Behaviour:
- Reset (axis_rst=1 at a posedge): all of the following are cleared; array contents are don't-care.
  - rd_ptr=0, wr_ptr=0, fifo_count=0.
  - m_tvalid=0, as_is_tready=0.
  - overflow=0, drop_cnt=0.
- Reset asserted mid-stream: the FIFO is flushed and queued beats are lost. as_is_tready rises on the first clock after reset deasserts, since the FIFO is empty and free=pDEPTH > pTHRESHOLD.
- Entry payload: {tlast, tid, tuser, tkeep, tstrb, tdata}, 45 bits at default parameters.
- wr = is_as_tvalid & (count<pDEPTH | rd).
- rd = m_tvalid & m_tready.
- Full with a simultaneous read: the write is accepted and count is unchanged.
- Full without a read, is_as_tvalid=1: the beat is dropped, overflow<=1, and drop_cnt increments, saturating at 255.
- ovf_clr and a drop in the same cycle: the drop wins; overflow=1, drop_cnt=1.
- Pointers advance by 1 per accepted op and wrap from pDEPTH-1 to 0 by explicit compare.
- count update: next = count + wr - rd. fifo_count is registered.
- m_* fields are driven from the entry at rd_ptr. m_tvalid = (count != 0).
- Latency from write to m_tvalid is 1 cycle; there is no fall-through bypass.
- While m_tvalid=1 and m_tready=0, the m_* fields hold stable (AXI-Stream rule).
- Empty with m_tready=1: no read occurs and pointers hold.
- as_is_tready is registered: as_is_tready <= (pDEPTH - next_count) > pTHRESHOLD.
  - Deassert: the cycle after free entries reach <= pTHRESHOLD.
  - Reassert: the cycle after free entries exceed pTHRESHOLD.
- Beats arriving after as_is_tready falls are still accepted while space remains.
- tlast is stored transparently; there is no packet-level logic.

Decomposition:
- Shared package fsic_axis_pkg holds:
  - Widths: DATA_W, STRB_W, TID_W=2, TUSER_W=2.
  - Payload width PAYLOAD_W.
  - Field offsets for packing and unpacking the entry.
- One sub-module, fsic_fifo_regfile: pDEPTH x PAYLOAD_W register array with one synchronous write port and one asynchronous read port.
- Control (pointers, count, watermark, overflow) stays in fsic_is_rx_fifo.

Test Plan:
- Reset, then idle → cycle 1 after reset: as_is_tready=1, m_tvalid=0, fifo_count=0.
- Single beat tdata=0xA5A5_0001, tid=2, tuser=1, tlast=1, m_tready=1 → next cycle m_tvalid=1 with identical fields. Following cycle fifo_count=0.
- Burst of 5 beats, m_tready=0 (pDEPTH=8, pTHRESHOLD=3) → after the 5th write fifo_count=5 and as_is_tready=0 on that same registered edge.
  - Pop one beat → free=4 and as_is_tready returns to 1.
- Burst of 10 beats with m_tready=0 → fifo_count=8, overflow=1, drop_cnt=2.
  - Drain → output order is beats 0..7 unchanged.
  - Pulse ovf_clr → overflow=0, drop_cnt=0.
- FIFO full, is_as_tvalid=1 and m_tready=1 for 20 cycles with counting tdata → no drops, fifo_count stays 8, output sequence is continuous across the pointer wrap.
- axis_rst pulsed with 6 entries queued → next cycle m_tvalid=0, fifo_count=0, as_is_tready=1 one cycle later, and no stale beat appears afterward.

Source files
------------

// File: rtl/fsic_axis_pkg.sv
// fsic_axis_pkg: shared AXI-Stream widths and FIFO entry layout {tlast, tid, tuser, tkeep, tstrb, tdata}.
package fsic_axis_pkg;

    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TID_W   = 2;
    localparam int TUSER_W = 2;

    function automatic int payload_w(input int dw);
        return dw + 2 * (dw / 8) + TUSER_W + TID_W + 1;
    endfunction

    function automatic int off_strb(input int dw);
        return dw;
    endfunction

    function automatic int off_keep(input int dw);
        return dw + dw / 8;
    endfunction

    function automatic int off_tuser(input int dw);
        return dw + 2 * (dw / 8);
    endfunction

    function automatic int off_tid(input int dw);
        return off_tuser(dw) + TUSER_W;
    endfunction

    function automatic int off_tlast(input int dw);
        return off_tid(dw) + TID_W;
    endfunction

    localparam int PAYLOAD_W = payload_w(DATA_W);

endpackage

// File: rtl/fsic_fifo_regfile.sv
// fsic_fifo_regfile: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write enable, address, data (captured on posedge)
//   raddr_i/rdata_o  combinational read of the addressed entry
module fsic_fifo_regfile #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 45,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsic_is_rx_fifo.sv
// fsic_is_rx_fifo: serdes Rx AXI-Stream buffer with registered link-level flow control and drop accounting.
//   axis_clk, axis_rst      clock, synchronous active-high reset
//   is_as_*                 beats from serdes Rx (no backpressure; every valid beat is offered)
//   as_is_tready            registered flow control toward remote, low when free <= pTHRESHOLD
//   m_*                     AXI-Stream master, fields driven from the head entry
//   fifo_count              occupied entries
//   overflow, drop_cnt      sticky drop flag and saturating drop counter, cleared by ovf_clr
module fsic_is_rx_fifo
    import fsic_axis_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_W,
    parameter int pDEPTH      = 8,
    parameter int pTHRESHOLD  = 3
) (
    input  logic                           axis_clk,
    input  logic                           axis_rst,
    input  logic [pDATA_WIDTH-1:0]         is_as_tdata,
    input  logic [pDATA_WIDTH/8-1:0]       is_as_tstrb,
    input  logic [pDATA_WIDTH/8-1:0]       is_as_tkeep,
    input  logic [TID_W-1:0]               is_as_tid,
    input  logic [TUSER_W-1:0]             is_as_tuser,
    input  logic                           is_as_tlast,
    input  logic                           is_as_tvalid,
    output logic                           as_is_tready,
    output logic [pDATA_WIDTH-1:0]         m_tdata,
    output logic [pDATA_WIDTH/8-1:0]       m_tstrb,
    output logic [pDATA_WIDTH/8-1:0]       m_tkeep,
    output logic [TID_W-1:0]               m_tid,
    output logic [TUSER_W-1:0]             m_tuser,
    output logic                           m_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [$clog2(pDEPTH+1)-1:0]    fifo_count,
    output logic                           overflow,
    output logic [7:0]                     drop_cnt,
    input  logic                           ovf_clr
);

    localparam int SW = pDATA_WIDTH / 8;
    localparam int PW = payload_w(pDATA_WIDTH);
    localparam int AW = $clog2(pDEPTH);
    localparam int CW = $clog2(pDEPTH + 1);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic          rd, wr, drop;
    logic [PW-1:0] wr_payload, rd_payload;

    assign wr_payload = {is_as_tlast, is_as_tid, is_as_tuser, is_as_tkeep, is_as_tstrb, is_as_tdata};

    fsic_fifo_regfile #(
        .DEPTH (pDEPTH),
        .WIDTH (PW),
        .AW    (AW)
    ) u_regfile (
        .clk_i   (axis_clk),
        .we_i    (wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_payload),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_payload)
    );

    assign m_tdata  = rd_payload[0 +: pDATA_WIDTH];
    assign m_tstrb  = rd_payload[off_strb(pDATA_WIDTH) +: SW];
    assign m_tkeep  = rd_payload[off_keep(pDATA_WIDTH) +: SW];
    assign m_tuser  = rd_payload[off_tuser(pDATA_WIDTH) +: TUSER_W];
    assign m_tid    = rd_payload[off_tid(pDATA_WIDTH) +: TID_W];
    assign m_tlast  = rd_payload[off_tlast(pDATA_WIDTH)];
    assign m_tvalid = count_q != '0;

    assign as_is_tready = ready_q;
    assign fifo_count   = count_q;
    assign overflow     = ovf_q;
    assign drop_cnt     = drop_q;

    always_comb begin
        rd       = m_tvalid & m_tready;
        // A full FIFO still accepts a beat when the head leaves in the same cycle.
        wr       = is_as_tvalid & ((count_q < CW'(pDEPTH)) | rd);
        drop     = is_as_tvalid & ~wr;
        rd_ptr_d = rd ? ((rd_ptr_q == AW'(pDEPTH - 1)) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
        wr_ptr_d = wr ? ((wr_ptr_q == AW'(pDEPTH - 1)) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        count_d  = count_q + CW'(wr) - CW'(rd);
        ready_d  = (CW'(pDEPTH) - count_d) > CW'(pTHRESHOLD);
        // A drop coinciding with a clear is still recorded.
        ovf_d    = drop | (ovf_q & ~ovf_clr);
        drop_d   = ovf_clr ? {7'd0, drop} : drop_q + {7'd0, drop & (drop_q != 8'hFF)};
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_fsic_is_rx_fifo.sv
// tb_fsic_is_rx_fifo: directed stimulus, queue-based reference model compared every cycle, plus literal checks.
module tb_fsic_is_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TH    = 3;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic [31:0] is_as_tdata;
    logic [3:0]  is_as_tstrb, is_as_tkeep;
    logic [1:0]  is_as_tid, is_as_tuser;
    logic        is_as_tlast, is_as_tvalid;
    logic        as_is_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb, m_tkeep;
    logic [1:0]  m_tid, m_tuser;
    logic        m_tlast, m_tvalid, m_tready;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    fsic_is_rx_fifo dut (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .is_as_tdata  (is_as_tdata),
        .is_as_tstrb  (is_as_tstrb),
        .is_as_tkeep  (is_as_tkeep),
        .is_as_tid    (is_as_tid),
        .is_as_tuser  (is_as_tuser),
        .is_as_tlast  (is_as_tlast),
        .is_as_tvalid (is_as_tvalid),
        .as_is_tready (as_is_tready),
        .m_tdata      (m_tdata),
        .m_tstrb      (m_tstrb),
        .m_tkeep      (m_tkeep),
        .m_tid        (m_tid),
        .m_tuser      (m_tuser),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .ovf_clr      (ovf_clr)
    );

    always #5 axis_clk = ~axis_clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: an ordered list of beats plus flags, advanced once per clock.
    logic [44:0] mq[$];
    bit          m_rdy, m_ovf;
    int          m_drop;
    bit          mr, ma, md;

    always @(posedge axis_clk) begin
        if (axis_rst) begin
            mq.delete();
            m_rdy  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            mr = (mq.size() != 0) && m_tready;
            ma = is_as_tvalid && (mq.size() < DEPTH || mr);
            md = is_as_tvalid && !ma;
            if (mr) void'(mq.pop_front());
            if (ma) mq.push_back({is_as_tlast, is_as_tid, is_as_tuser, is_as_tkeep, is_as_tstrb, is_as_tdata});
            m_ovf  = md || (m_ovf && !ovf_clr);
            m_drop = ovf_clr ? (md ? 1 : 0) : ((md && m_drop < 255) ? m_drop + 1 : m_drop);
            m_rdy  = (DEPTH - mq.size()) > TH;
        end
    end

    always @(negedge axis_clk) begin
        if (chk_en) begin
            chk("m_tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
            chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
            chk("as_is_tready", 64'(as_is_tready), 64'(m_rdy));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (mq.size() != 0)
                chk("m_payload", 64'({m_tlast, m_tid, m_tuser, m_tkeep, m_tstrb, m_tdata}), 64'(mq[0]));
        end
    end

    task automatic cyc();
        @(negedge axis_clk);
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] id, input logic [1:0] us, input logic l);
        is_as_tdata  = d;
        is_as_tstrb  = d[3:0];
        is_as_tkeep  = d[7:4];
        is_as_tid    = id;
        is_as_tuser  = us;
        is_as_tlast  = l;
        is_as_tvalid = 1'b1;
    endtask

    initial begin
        axis_rst     = 1'b1;
        is_as_tdata  = '0;
        is_as_tstrb  = '0;
        is_as_tkeep  = '0;
        is_as_tid    = '0;
        is_as_tuser  = '0;
        is_as_tlast  = 1'b0;
        is_as_tvalid = 1'b0;
        m_tready     = 1'b0;
        ovf_clr      = 1'b0;
        cyc();
        chk_en = 1;
        chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst fifo_count", 64'(fifo_count), 64'd0);
        chk("rst as_is_tready", 64'(as_is_tready), 64'd0);
        axis_rst = 1'b0;
        cyc();
        chk("idle as_is_tready", 64'(as_is_tready), 64'd1);
        chk("idle m_tvalid", 64'(m_tvalid), 64'd0);

        m_tready = 1'b1;
        beat(32'hA5A5_0001, 2'd2, 2'd1, 1'b1);
        cyc();
        is_as_tvalid = 1'b0;
        chk("single m_tvalid", 64'(m_tvalid), 64'd1);
        chk("single m_tdata", 64'(m_tdata), 64'hA5A5_0001);
        chk("single fields", 64'({m_tid, m_tuser, m_tlast}), 64'b10_01_1);
        cyc();
        chk("single drained", 64'(fifo_count), 64'd0);

        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(32'h0000_0010 + 32'(i), 2'(i), 2'(i + 1), i == 4);
            cyc();
        end
        is_as_tvalid = 1'b0;
        chk("burst5 count", 64'(fifo_count), 64'd5);
        chk("burst5 tready low", 64'(as_is_tready), 64'd0);
        m_tready = 1'b1;
        cyc();
        m_tready = 1'b0;
        chk("pop1 count", 64'(fifo_count), 64'd4);
        chk("pop1 tready high", 64'(as_is_tready), 64'd1);
        m_tready = 1'b1;
        repeat (4) cyc();
        m_tready = 1'b0;
        chk("burst5 drained", 64'(fifo_count), 64'd0);

        for (int i = 0; i < 10; i++) begin
            beat(32'h0000_0100 + 32'(i), 2'd1, 2'd3, 1'b0);
            cyc();
        end
        is_as_tvalid = 1'b0;
        chk("burst10 count", 64'(fifo_count), 64'd8);
        chk("burst10 overflow", 64'(overflow), 64'd1);
        chk("burst10 drop_cnt", 64'(drop_cnt), 64'd2);
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain order", 64'(m_tdata), 64'h100 + 64'(i));
            cyc();
        end
        m_tready = 1'b0;
        chk("drained empty", 64'(m_tvalid), 64'd0);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("clr overflow", 64'(overflow), 64'd0);
        chk("clr drop_cnt", 64'(drop_cnt), 64'd0);

        for (int i = 0; i < 8; i++) begin
            beat(32'h0000_0200 + 32'(i), 2'd0, 2'd0, 1'b0);
            cyc();
        end
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("wrap count", 64'(fifo_count), 64'd8);
            chk("wrap order", 64'(m_tdata), 64'h200 + 64'(i));
            beat(32'h0000_0208 + 32'(i), 2'd3, 2'd2, i[0]);
            cyc();
        end
        is_as_tvalid = 1'b0;
        chk("wrap no drops", 64'(drop_cnt), 64'd0);
        chk("wrap head", 64'(m_tdata), 64'h214);
        repeat (2) cyc();
        m_tready = 1'b0;
        chk("pre-rst count", 64'(fifo_count), 64'd6);

        axis_rst = 1'b1;
        cyc();
        axis_rst = 1'b0;
        chk("midrst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst fifo_count", 64'(fifo_count), 64'd0);
        chk("midrst tready low", 64'(as_is_tready), 64'd0);
        cyc();
        chk("postrst tready", 64'(as_is_tready), 64'd1);
        chk("postrst no stale", 64'(m_tvalid), 64'd0);
        beat(32'h0000_0300, 2'd1, 2'd0, 1'b1);
        cyc();
        is_as_tvalid = 1'b0;
        chk("postrst fresh beat", 64'(m_tdata), 64'h300);
        chk("postrst count", 64'(fifo_count), 64'd1);

        for (int i = 0; i < 270; i++) begin
            beat(32'h0000_0400 + 32'(i), 2'd0, 2'd1, 1'b0);
            cyc();
        end
        chk("saturate drop_cnt", 64'(drop_cnt), 64'd255);
        chk("saturate head", 64'(m_tdata), 64'h300);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        is_as_tvalid = 1'b0;
        chk("clr+drop overflow", 64'(overflow), 64'd1);
        chk("clr+drop drop_cnt", 64'(drop_cnt), 64'd1);
        m_tready = 1'b1;
        repeat (10) cyc();
        chk("final empty", 64'(fifo_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
